// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// the NOP word held in the instruction register out of reset, and the
// FSM state encoding.
package fetch_unit_pkg;

  localparam int FU_ADDR_W = 16;
  localparam int FU_DATA_W = 16;

  // NOP encoding presented while no valid instruction is held
  localparam logic [15:0] FU_RESET_INSTR = 16'h0000;

  localparam logic [1:0] FU_ST_START_ENC = 2'd0;
  localparam logic [1:0] FU_ST_REQ_ENC   = 2'd1;
  localparam logic [1:0] FU_ST_DRAIN_ENC = 2'd2;
  localparam logic [1:0] FU_ST_HOLD_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_START = FU_ST_START_ENC,  // sample PC, no request outstanding
    ST_REQ   = FU_ST_REQ_ENC,    // read outstanding, response wanted
    ST_DRAIN = FU_ST_DRAIN_ENC,  // read outstanding, response discarded
    ST_HOLD  = FU_ST_HOLD_ENC    // instruction presented to decode
  } fu_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its neighbours (PC, instruction
// memory, decode). The master modport is the fetch stage's view; the slave
// modport is the environment's view.
//
// Handshakes:
//   imem_req/imem_ack : imem_req stays high with imem_addr stable until the
//                       cycle imem_ack=1; imem_data is only meaningful in
//                       that cycle. One outstanding read at a time.
//   instr_valid/instr_ready : a transfer happens on a clock edge where both
//                       are high and flush is low; while valid and not
//                       transferred, instr is held stable.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = FU_ADDR_W,
  parameter int DATA_W = FU_DATA_W
) ();

  logic [ADDR_W-1:0] pc_in;
  logic              pc_inc;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  fu_state_e         dbg_state;

  modport master (
    input  pc_in, flush, imem_ack, imem_data, instr_ready,
    output pc_inc, imem_req, imem_addr, instr, instr_valid, dbg_state
  );

  modport slave (
    output pc_in, flush, imem_ack, imem_data, instr_ready,
    input  pc_inc, imem_req, imem_addr, instr, instr_valid, dbg_state
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Captures the PC into a registered read address,
// runs one memory read per instruction over req/ack, stores the returned
// word and offers it to decode. A jump (flush) abandons the fetch in flight;
// a read already issued is drained so its late response cannot be mistaken
// for the new path's data.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W      = FU_ADDR_W,
  parameter int                DATA_W      = FU_DATA_W,
  parameter logic [DATA_W-1:0] RESET_INSTR = FU_RESET_INSTR
) (
  input  logic         clock,
  input  logic         reset_n,
  fetch_unit_if.master bus
);

  fu_state_e         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_instr;

  logic w_req;
  logic w_valid;
  logic w_pc_inc;

  // Handshake outputs decode directly from the state register so that an
  // asynchronous reset removes them without waiting for a clock edge.
  always_comb begin
    w_req    = (r_state == ST_REQ) || (r_state == ST_DRAIN);
    w_valid  = (r_state == ST_HOLD);
    // Advance the PC exactly when a wanted word is captured; never on a jump.
    w_pc_inc = (r_state == ST_REQ) && bus.imem_ack && !bus.flush;
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_valid = w_valid;
  assign bus.pc_inc      = w_pc_inc;
  assign bus.dbg_state   = r_state;

  // Fetch FSM with the address and instruction registers it owns.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_START;
      r_addr  <= '0;
      r_instr <= RESET_INSTR;
    end else begin
      unique case (r_state)
        ST_START: begin
          // During a jump the PC loads on this edge, so pc_in is stale.
          if (!bus.flush) begin
            r_addr  <= bus.pc_in;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.imem_ack) begin
            if (bus.flush) begin
              r_state <= ST_START;
            end else begin
              r_instr <= bus.imem_data;
              r_state <= ST_HOLD;
            end
          end else if (bus.flush) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The response to the abandoned read is thrown away.
          if (bus.imem_ack) begin
            r_state <= ST_START;
          end
        end
        ST_HOLD: begin
          // A jump wins over decode accepting the wrong-path instruction.
          if (bus.flush || bus.instr_ready) begin
            r_state <= ST_START;
          end
        end
        default: r_state <= ST_START;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for the fetch stage. The environment emulates the PC (load on jump,
// increment on pc_inc) and an instruction memory whose contents are a fixed
// function of address with a per-read random latency. The expected queue
// holds the program-order instruction stream starting at the current jump
// target; every instruction decode accepts must be the next one in it.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clock;
  logic reset_n;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;
  int rst_epoch = 0;

  logic [15:0] exp_q[$];
  logic [15:0] stream_pc;

  // environment state
  logic [15:0] pc_q, pc_nxt;
  int          wait_cnt, wait_target;
  int          fixed_wait = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [31:0] p;
    p = 32'(a) * 32'd40503;
    return p[15:0] ^ 16'h1234;
  endfunction

  function automatic int pick_wait();
    if (fixed_wait >= 0) return fixed_wait;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(mem_word(stream_pc));
      stream_pc = stream_pc + 16'd1;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Asserts reset at the current time (asynchronously), checks the reset
  // outputs, then releases just after a falling edge with the PC at start_pc.
  task automatic do_reset(input logic [15:0] start_pc);
    reset_n = 1'b0;
    rst_epoch++;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_data   = '0;
    pc_q   = start_pc;
    pc_nxt = start_pc;
    bus.pc_in = start_pc;
    wait_cnt    = 0;
    wait_target = pick_wait();
    exp_q.delete();
    stream_pc = start_pc;
    refill();
    #1;
    chk("rst_req",    32'(bus.imem_req),    32'd0);
    chk("rst_valid",  32'(bus.instr_valid), 32'd0);
    chk("rst_pc_inc", 32'(bus.pc_inc),      32'd0);
    chk("rst_instr",  32'(bus.instr),       32'(FU_RESET_INSTR));
    chk("rst_addr",   32'(bus.imem_addr),   32'd0);
    chk("rst_state",  32'(bus.dbg_state),   32'(ST_START));
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
  endtask

  // One clock cycle: apply inputs after the rising edge, return at the
  // falling edge with this cycle's outputs settled.
  task automatic tick(input bit f, input bit r, input logic [15:0] tgt);
    @(posedge clock);
    #1;
    pc_q = pc_nxt;
    bus.pc_in = pc_q;
    if (bus.imem_req && (wait_cnt >= wait_target)) begin
      bus.imem_ack  = 1'b1;
      bus.imem_data = mem_word(bus.imem_addr);
    end else begin
      bus.imem_ack  = 1'b0;
      bus.imem_data = 16'($urandom);
    end
    bus.flush       = f;
    bus.instr_ready = r;
    if (f) begin
      exp_q.delete();
      stream_pc = tgt;
    end
    refill();
    @(negedge clock);
    if (bus.flush)       pc_nxt = tgt;
    else if (bus.pc_inc) pc_nxt = pc_q + 16'd1;
    else                 pc_nxt = pc_q;
    if (bus.imem_req) begin
      if (bus.imem_ack) begin
        wait_cnt    = 0;
        wait_target = pick_wait();
      end else begin
        wait_cnt++;
      end
    end
  endtask

  // ---------------- monitor ----------------
  bit          p_ok;
  int          p_epoch;
  logic        p_req, p_ack, p_valid, p_ready, p_flush;
  logic [15:0] p_addr, p_instr;
  logic [15:0] got_exp;

  // Checks handshake rules cycle by cycle and pops the expected stream on
  // every accepted instruction.
  always @(negedge clock) begin
    if (!reset_n) begin
      p_ok = 1'b0;
    end else begin
      if (p_ok && (p_epoch == rst_epoch)) begin
        if (p_req && !p_ack) begin
          chk("req_hold",  32'(bus.imem_req),  32'd1);
          chk("addr_hold", 32'(bus.imem_addr), 32'(p_addr));
        end
        if (p_valid && !p_ready && !p_flush) begin
          chk("valid_hold", 32'(bus.instr_valid), 32'd1);
          chk("instr_hold", 32'(bus.instr),       32'(p_instr));
        end
      end
      if (bus.pc_inc)
        chk("pc_inc_cause", 32'(bus.imem_req && bus.imem_ack && !bus.flush), 32'd1);
      if (bus.flush)
        chk("pc_inc_flush", 32'(bus.pc_inc), 32'd0);
      if (bus.instr_valid)
        chk("req_in_hold", 32'(bus.imem_req), 32'd0);
      if (bus.instr_valid && bus.instr_ready && !bus.flush) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          chk("instr_q_empty", 32'd0, 32'd1);
        end else begin
          got_exp = exp_q.pop_front();
          chk("instr", 32'(bus.instr), 32'(got_exp));
        end
      end
      p_req   = bus.imem_req;
      p_ack   = bus.imem_ack;
      p_valid = bus.instr_valid;
      p_ready = bus.instr_ready;
      p_flush = bus.flush;
      p_addr  = bus.imem_addr;
      p_instr = bus.instr;
      p_epoch = rst_epoch;
      p_ok    = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    reset_n = 1'b1;
    bus.flush = 1'b0; bus.instr_ready = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_data = '0; bus.pc_in = '0;
    #1;

    // Zero-wait fetch from 0, decode always ready.
    fixed_wait = 0;
    do_reset(16'h0000);
    tick(0, 1, '0);
    chk("z_req",    32'(bus.imem_req),  32'd1);
    chk("z_addr",   32'(bus.imem_addr), 32'd0);
    chk("z_pc_inc", 32'(bus.pc_inc),    32'd1);
    tick(0, 1, '0);
    chk("z_valid",  32'(bus.instr_valid), 32'd1);
    chk("z_instr",  32'(bus.instr),       32'h1234);
    chk("z_req2",   32'(bus.imem_req),    32'd0);
    tick(0, 1, '0);
    chk("z_start_valid", 32'(bus.instr_valid), 32'd0);
    tick(0, 1, '0);
    chk("z_next_addr", 32'(bus.imem_addr), 32'd1);

    // Memory ack delayed three cycles.
    fixed_wait = 3;
    do_reset(16'h0010);
    for (int i = 1; i <= 4; i++) begin
      tick(0, 1, '0);
      chk("w_req",    32'(bus.imem_req),  32'd1);
      chk("w_addr",   32'(bus.imem_addr), 32'h0010);
      chk("w_pc_inc", 32'(bus.pc_inc),    32'(i == 4));
    end
    tick(0, 1, '0);
    chk("w_instr", 32'(bus.instr), 32'(mem_word(16'h0010)));

    // Decode back-pressure for five HOLD cycles.
    fixed_wait = 0;
    do_reset(16'h0020);
    tick(0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, '0);
      chk("bp_valid",  32'(bus.instr_valid), 32'd1);
      chk("bp_instr",  32'(bus.instr),       32'(mem_word(16'h0020)));
      chk("bp_req",    32'(bus.imem_req),    32'd0);
      chk("bp_pc_inc", 32'(bus.pc_inc),      32'd0);
    end
    tick(0, 1, '0);
    tick(0, 1, '0);
    tick(0, 1, '0);
    chk("bp_resume_addr", 32'(bus.imem_addr), 32'h0021);

    // Jump during REQ, ack two cycles later: drained.
    fixed_wait = 2;
    do_reset(16'h0030);
    tick(1, 1, 16'h0040);
    chk("dr_pc_inc0", 32'(bus.pc_inc), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick(0, 1, '0);
      chk("dr_req",    32'(bus.imem_req),    32'd1);
      chk("dr_addr",   32'(bus.imem_addr),   32'h0030);
      chk("dr_pc_inc", 32'(bus.pc_inc),      32'd0);
      chk("dr_valid",  32'(bus.instr_valid), 32'd0);
    end
    tick(0, 1, '0);
    chk("dr_start_req",   32'(bus.imem_req),    32'd0);
    chk("dr_start_valid", 32'(bus.instr_valid), 32'd0);
    tick(0, 1, '0);
    chk("dr_new_addr", 32'(bus.imem_addr), 32'h0040);
    for (int i = 0; i < 4; i++) tick(0, 1, '0);

    // Jump coincident with ack in REQ.
    fixed_wait = 0;
    do_reset(16'h0050);
    tick(1, 1, 16'h0060);
    chk("fa_pc_inc", 32'(bus.pc_inc), 32'd0);
    tick(0, 1, '0);
    chk("fa_valid", 32'(bus.instr_valid), 32'd0);
    chk("fa_req",   32'(bus.imem_req),    32'd0);
    tick(0, 1, '0);
    chk("fa_addr", 32'(bus.imem_addr), 32'h0060);
    tick(0, 1, '0);

    // Jump coincident with instr_ready in HOLD.
    do_reset(16'h0070);
    tick(0, 0, '0);
    tick(1, 1, 16'h0080);
    chk("fh_valid_now", 32'(bus.instr_valid), 32'd1);
    chk("fh_pc_inc",    32'(bus.pc_inc),      32'd0);
    tick(0, 1, '0);
    chk("fh_valid_next", 32'(bus.instr_valid), 32'd0);
    tick(0, 1, '0);
    chk("fh_addr", 32'(bus.imem_addr), 32'h0080);
    tick(0, 1, '0);
    tick(0, 1, '0);

    // Late ack while in START is ignored.
    do_reset(16'h0090);
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'hdead;
    tick(0, 1, '0);
    chk("la_addr", 32'(bus.imem_addr), 32'h0090);
    tick(0, 1, '0);
    chk("la_instr", 32'(bus.instr), 32'(mem_word(16'h0090)));

    // Asynchronous reset in the middle of a REQ cycle.
    fixed_wait = 3;
    do_reset(16'h0100);
    tick(0, 1, '0);
    chk("ar_pre_req", 32'(bus.imem_req), 32'd1);
    #2;
    do_reset(16'h0200);
    tick(0, 1, '0);
    chk("ar_addr", 32'(bus.imem_addr), 32'h0200);
    for (int i = 0; i < 5; i++) tick(0, 1, '0);

    // Asynchronous reset while holding an instruction.
    fixed_wait = 0;
    do_reset(16'h0300);
    tick(0, 0, '0);
    tick(0, 0, '0);
    chk("ah_pre_valid", 32'(bus.instr_valid), 32'd1);
    #2;
    do_reset(16'h0310);
    for (int i = 0; i < 3; i++) tick(0, 1, '0);

    // Random traffic: jumps, back-pressure, variable memory latency.
    fixed_wait = -1;
    do_reset(16'($urandom));
    d0 = n_deliv;
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0), 16'($urandom));
    end
    chk("rand_progress", 32'(n_deliv - d0 >= 50), 32'd1);

    tick(0, 0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
